button_conditioner: RTL

Multi-button input conditioner that feeds the control core's button ports. It turns raw, asynchronous, bouncing board buttons into clean per-button signals:
- a debounced level (`btn_lvl`, driving `l_btn` … `c_btn`)
- a one-cycle press pulse (`btn_dn`, driving `l_btn_dn` … `c_btn_dn`)
- a release pulse (`btn_up`)
- a typematic auto-repeat pulse (`btn_rep`)

It sits between the board pins and the core's input-mode stage, clocked by the 40 MHz pixel clock.

---
 rtl/input_pkg.sv | 30 +++
 rtl/button_channel.sv | 149 ++++++++++++++
 rtl/button_conditioner.sv | 54 +++++
 3 files changed

// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared types and constants for the button conditioner.
//   btn_state_t     : per-button debounce / typematic FSM state
//   *_CYC_DEF       : default timing at the 40 MHz pixel clock
//   BTN_L..BTN_C    : bit positions of the board buttons in the vectors
// -----------------------------------------------------------------------------
package input_pkg;

  typedef enum logic [2:0] {
    RELEASED  = 3'd0,
    ARMING    = 3'd1,
    PRESSED   = 3'd2,
    REPEAT    = 3'd3,
    DISARMING = 3'd4
  } btn_state_t;

  localparam int STATE_W = $bits(btn_state_t);

  localparam int DEBOUNCE_CYC_DEF = 400000;    // 10 ms
  localparam int HOLD_CYC_DEF     = 20000000;  // 500 ms
  localparam int REPEAT_CYC_DEF   = 4000000;   // 100 ms

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One button: 2-flop synchronizer, debounce/typematic FSM and its counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_raw     : raw asynchronous pin level, 1 = pressed
//   o_lvl     : debounced level (registered)
//   o_dn      : one-cycle pulse on accepted press
//   o_up      : one-cycle pulse on accepted release
//   o_rep     : one-cycle pulse on press and on each auto-repeat
//   o_state   : current FSM state, for observation
// DEBOUNCE_CYC must be at least 2: ARMING/DISARMING are entered with cnt=1.
// -----------------------------------------------------------------------------
module button_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF,
  parameter int REPEAT_CYC   = REPEAT_CYC_DEF,
  parameter int CNTW         = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_raw,
  output logic       o_lvl,
  output logic       o_dn,
  output logic       o_up,
  output logic       o_rep,
  output btn_state_t o_state
);

  localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE_CYC - 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYC - 1);
  localparam logic [CNTW-1:0] REP_LAST  = CNTW'(REPEAT_CYC - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  logic            r_sync1;
  logic            r_sync2;
  btn_state_t      r_state;
  btn_state_t      w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            r_lvl, r_dn, r_up, r_rep;
  logic            w_lvl_nxt, w_dn_nxt, w_up_nxt, w_rep_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dn_nxt    = 1'b0;
    w_up_nxt    = 1'b0;
    w_rep_nxt   = 1'b0;
    case (r_state)
      RELEASED: begin
        w_cnt_nxt = '0;
        if (r_sync2) begin
          w_state_nxt = ARMING;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ARMING: begin
        if (!r_sync2) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_dn_nxt    = 1'b1;
          w_rep_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = DISARMING;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = REPEAT;
          w_cnt_nxt   = '0;
          w_rep_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!r_sync2) begin
          w_state_nxt = DISARMING;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt == REP_LAST) begin
          w_cnt_nxt = '0;
          w_rep_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DISARMING: begin
        // A return to pressed inside the window is a dropout, not a new
        // press: no pulses, and the hold delay starts over.
        if (r_sync2) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
          w_up_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level follows the next state so it changes on the same edge as dn/up.
  assign w_lvl_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == REPEAT) ||
                     (w_state_nxt == DISARMING);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_dn    <= 1'b0;
      r_up    <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lvl   <= w_lvl_nxt;
      r_dn    <= w_dn_nxt;
      r_up    <= w_up_nxt;
      r_rep   <= w_rep_nxt;
    end
  end

  assign o_lvl   = r_lvl;
  assign o_dn    = r_dn;
  assign o_up    = r_up;
  assign o_rep   = r_rep;
  assign o_state = r_state;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions NBTN raw board buttons (bit order L, R, U, D, C, LSB first) into
// debounced levels plus press, release and typematic repeat pulses.
// Ports:
//   clk, rst   : 40 MHz pixel clock, synchronous active-high reset
//   btn_raw    : raw asynchronous pins, 1 = pressed
//   btn_lvl    : debounced levels
//   btn_dn     : one-cycle press pulses
//   btn_up     : one-cycle release pulses
//   btn_rep    : one-cycle pulses on press and on each auto-repeat
//   dbg_state  : per-button FSM state, STATE_W bits per button, LSB first
// -----------------------------------------------------------------------------
module button_conditioner
  import input_pkg::*;
#(
  parameter int NBTN         = 5,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF,
  parameter int REPEAT_CYC   = REPEAT_CYC_DEF,
  parameter int CNTW         = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NBTN-1:0]         btn_raw,
  output logic [NBTN-1:0]         btn_lvl,
  output logic [NBTN-1:0]         btn_dn,
  output logic [NBTN-1:0]         btn_up,
  output logic [NBTN-1:0]         btn_rep,
  output logic [NBTN*STATE_W-1:0] dbg_state
);

  btn_state_t w_state [NBTN];

  for (genvar g = 0; g < NBTN; g++) begin : gen_ch
    button_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .CNTW         (CNTW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (btn_raw[g]),
      .o_lvl   (btn_lvl[g]),
      .o_dn    (btn_dn[g]),
      .o_up    (btn_up[g]),
      .o_rep   (btn_rep[g]),
      .o_state (w_state[g])
    );
    assign dbg_state[g*STATE_W +: STATE_W] = w_state[g];
  end

endmodule
